uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : 8N1 UART transmitter fed by a DEPTH-entry byte FIFO.
//            Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic [15:0] divisor,
  input  logic        write_strobe,
  input  logic [7:0]  data_in,
  input  logic        clear_overflow,
  output logic        tx,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic [4:0]  count,
  output logic        overflow
);

  localparam int         PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_full_count = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t r_state, w_state_next;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]       r_count;
  logic             r_overflow;

  logic [7:0]  r_shift, w_shift_next;
  logic [2:0]  r_bit_idx, w_bit_idx_next;
  logic [15:0] r_div, w_div_next;
  logic [15:0] r_bit_cnt, w_bit_cnt_next;
  logic        r_tx, w_tx_next;

  logic w_full, w_empty, w_push, w_pop, w_bit_done;

  assign w_full     = (r_count == c_full_count);
  assign w_empty    = (r_count == 5'd0);
  assign w_push     = write_strobe && !w_full;
  assign w_bit_done = (r_bit_cnt == r_div);

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_div_next     = r_div;
    w_bit_cnt_next = w_bit_done ? 16'd0 : r_bit_cnt + 16'd1;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_bit_cnt_next = 16'd0;
        if (!w_empty) w_pop = 1'b1;
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          // Rotate rather than shift so the byte survives intact for parity.
          w_shift_next = {r_shift[0], r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = ^r_shift;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_done) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_done) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase

    // A pop always launches a new frame; divisor is captured only here.
    if (w_pop) begin
      w_state_next   = S_START;
      w_shift_next   = r_mem[r_rd_ptr];
      w_div_next     = divisor;
      w_bit_cnt_next = 16'd0;
      w_tx_next      = 1'b0;
    end
  end

  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_div      <= 16'd0;
      r_bit_cnt  <= 16'd0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_div     <= w_div_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (write_strobe && w_full) r_overflow <= 1'b1;
      else if (clear_overflow)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge raw_clk) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= data_in;
  end

  assign tx       = r_tx;
  assign full     = w_full;
  assign empty    = w_empty;
  assign busy     = (r_state != S_IDLE);
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
